// File: rtl/regfile_wb_sink_pkg.sv
// Shared defaults and constants for the decode-stage register file.
package regfile_wb_sink_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;

    // Index of the hardwired-zero register.
    localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/regfile_bypass_port.sv
// Per-port GPR read mux: stored value, write-back bypass, register-zero force.
module regfile_bypass_port
    import regfile_wb_sink_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [DATA_W-1:0] stored_i,
    input  logic              wb_en_i,
    input  logic [ADDR_W-1:0] wb_addr_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic [DATA_W-1:0] rd_data_o
);

    // Zero-force wins over a pending bypass to index 0.
    always_comb begin
        rd_data_o = stored_i;
        if (rd_addr_i == ADDR_W'(REG_ZERO)) begin
            rd_data_o = '0;
        end else if (wb_en_i && (wb_addr_i == rd_addr_i)) begin
            rd_data_o = wb_data_i;
        end
    end

endmodule

// File: rtl/regfile_wb_sink.sv
// Decode-stage register file: 32 GPRs plus HI/LO, fed by the write-back bus,
// with internal write-to-read bypass on every read port.
module regfile_wb_sink
    import regfile_wb_sink_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              RegWrite_WB,
    input  logic [ADDR_W-1:0] WriteReg_WB,
    input  logic [DATA_W-1:0] WriteData_WB,
    input  logic              HiLoWrite_WB,
    input  logic [DATA_W-1:0] HiData_WB,
    input  logic [DATA_W-1:0] LoData_WB,
    input  logic [ADDR_W-1:0] ReadReg1_ID,
    input  logic [ADDR_W-1:0] ReadReg2_ID,
    output logic [DATA_W-1:0] ReadData1_ID,
    output logic [DATA_W-1:0] ReadData2_ID,
    output logic [DATA_W-1:0] Hi_ID,
    output logic [DATA_W-1:0] Lo_ID,
    output logic [15:0]       WriteCount
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] hi_q, lo_q;
    logic [15:0]       count_q, count_d;
    logic              gpr_commit;

    // A GPR write commits only to a nonzero index.
    always_comb begin
        gpr_commit = RegWrite_WB && (WriteReg_WB != ADDR_W'(REG_ZERO));
        count_d    = count_q;
        if (gpr_commit) begin
            count_d = count_q + 16'd1;
        end
    end

    // Storage, HI/LO and write counter; reset discards same-cycle writes.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            hi_q    <= '0;
            lo_q    <= '0;
            count_q <= '0;
        end else begin
            if (gpr_commit) begin
                regs_q[WriteReg_WB] <= WriteData_WB;
            end
            if (HiLoWrite_WB) begin
                hi_q <= HiData_WB;
                lo_q <= LoData_WB;
            end
            count_q <= count_d;
        end
    end

    regfile_bypass_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_port1 (
        .rd_addr_i (ReadReg1_ID),
        .stored_i  (regs_q[ReadReg1_ID]),
        .wb_en_i   (RegWrite_WB),
        .wb_addr_i (WriteReg_WB),
        .wb_data_i (WriteData_WB),
        .rd_data_o (ReadData1_ID)
    );

    regfile_bypass_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_port2 (
        .rd_addr_i (ReadReg2_ID),
        .stored_i  (regs_q[ReadReg2_ID]),
        .wb_en_i   (RegWrite_WB),
        .wb_addr_i (WriteReg_WB),
        .wb_data_i (WriteData_WB),
        .rd_data_o (ReadData2_ID)
    );

    // HI/LO read with bypass of the pending write-back values.
    always_comb begin
        Hi_ID = HiLoWrite_WB ? HiData_WB : hi_q;
        Lo_ID = HiLoWrite_WB ? LoData_WB : lo_q;
    end

    assign WriteCount = count_q;

endmodule
